// File: rtl/program_loader.sv
// Byte-stream program loader: packs little-endian 32-bit words into instruction memory
// and holds the processor in reset until a clean load has completed.
module program_loader #(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  words_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           byte_cnt;
  logic [23:0]          buffer;
  logic                 last_seen;
  logic [CNT_WIDTH-1:0] word_idx;
  logic                 accept;
  logic                 full;
  logic                 restart;

  assign accept       = (state == LOAD) && in_valid;
  assign full         = (word_idx == CNT_WIDTH'(DEPTH));
  assign restart      = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign words_loaded = word_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (byte_cnt == 2'd3) state_nxt = full ? ERROR : WRITE;
          else if (in_last)     state_nxt = ERROR;
        end
      end
      WRITE:   state_nxt = last_seen ? DONE : LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    cpu_reset = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      LOAD:  in_ready = 1'b1;
      WRITE: mem_we = 1'b1;
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      ERROR:   error = 1'b1;
      default: ;
    endcase
  end

  // Word assembly: lanes 0..2 buffer up; the 4th byte completes the word directly into mem_wdata.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt  <= 2'd0;
      buffer    <= 24'd0;
      last_seen <= 1'b0;
      word_idx  <= '0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      if (restart) begin
        byte_cnt <= 2'd0;
        word_idx <= '0;
      end
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: buffer[7:0]   <= in_data;
          2'd1: buffer[15:8]  <= in_data;
          2'd2: buffer[23:16] <= in_data;
          default: begin
            if (!full) begin
              mem_wdata <= {in_data, buffer};
              mem_addr  <= ADDR_WIDTH'({word_idx, 2'b00});
              last_seen <= in_last;
            end
          end
        endcase
      end
      if (state == WRITE) word_idx <= word_idx + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written corner sequences and
// randomized programs scored against a word-level reference model.
module tb_program_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int CW    = 16;

  logic          clock;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset;
  logic          done;
  logic          error;
  logic [CW-1:0] words_loaded;

  program_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int acc_cyc;
  int ready_in_write;

  logic [7:0]  prog[0:31];
  logic [31:0] exp_data[$];
  bit          m_ok;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
      if (in_ready) ready_in_write++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Program of n bytes, last flag on byte n-1; result is the list of words that must land
  // in memory and whether the load ends cleanly.
  task automatic model_run(input int n, output int stop, output bit ok);
    exp_data.delete();
    stop = n - 1;
    ok   = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i % 4 == 3) begin
        if (i / 4 == DEPTH) begin
          stop = i;
          ok   = 1'b0;
          return;
        end
        exp_data.push_back({prog[i], prog[i-1], prog[i-2], prog[i-3]});
        if (i == n - 1) begin
          stop = i;
          ok   = 1'b1;
          return;
        end
      end else if (i == n - 1) begin
        stop = i;
        ok   = 1'b0;
        return;
      end
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 20) begin
      @(negedge clock);
      t++;
    end
    ok = in_ready;
    if (ok) begin
      @(negedge clock);
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_load(input int n, input int maxgap);
    int stop;
    int g;
    bit ok;
    model_run(n, stop, m_ok);
    @(negedge clock);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    ready_in_write = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i <= stop; i++) begin
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) @(negedge clock);
      send_byte(prog[i], logic'(i == n - 1), ok);
      if (!ok) begin
        check("ready_timeout", 64'(in_ready), 64'd1);
        return;
      end
    end
    repeat (3) @(negedge clock);
  endtask

  typedef struct {
    int          len;
    logic [159:0] bytes;
    bit          exp_done;
    int          exp_words;
    logic [31:0] exp_last_word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{4,  160'h8B120200, 1'b1, 1, 32'h8B120200};
    vecs[1] = '{2,  160'hBBAA, 1'b0, 0, 32'h0};
    vecs[2] = '{8,  160'h0807060504030201, 1'b1, 2, 32'h08070605};
    vecs[3] = '{7,  160'h07060504030201, 1'b0, 1, 32'h04030201};
    vecs[4] = '{16, 160'h100F0E0D0C0B0A090807060504030201, 1'b1, 4, 32'h100F0E0D};
    vecs[5] = '{20, 160'h14131211100F0E0D0C0B0A090807060504030201, 1'b0, 4, 32'h100F0E0D};
    vecs[6] = '{1,  160'h55, 1'b0, 0, 32'h0};

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    ready_in_write = 0;
    acc_cyc  = 0;
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 20; i++) prog[i] = vecs[v].bytes[8*i +: 8];
      do_load(vecs[v].len, 0);
      check($sformatf("tbl%0d_nwrites", v), 64'(wr_data.size()), 64'(vecs[v].exp_words));
      check($sformatf("tbl%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      check($sformatf("tbl%0d_error", v), 64'(error), 64'(!vecs[v].exp_done));
      check($sformatf("tbl%0d_cpu_reset", v), 64'(cpu_reset), 64'(!vecs[v].exp_done));
      check($sformatf("tbl%0d_words", v), 64'(words_loaded), 64'(vecs[v].exp_words));
      if (vecs[v].exp_words > 0 && wr_data.size() > 0) begin
        check($sformatf("tbl%0d_last_word", v), 64'(wr_data[wr_data.size()-1]),
              64'(vecs[v].exp_last_word));
        check($sformatf("tbl%0d_last_addr", v), wr_addr[wr_addr.size()-1],
              64'(4 * (vecs[v].exp_words - 1)));
      end
    end

    // Basic load, write latency, then restart from DONE.
    prog[0] = 8'h00; prog[1] = 8'h02; prog[2] = 8'h12; prog[3] = 8'h8B;
    do_load(4, 0);
    check("t1_nwrites", 64'(wr_data.size()), 64'd1);
    if (wr_data.size() > 0) begin
      check("t1_wdata", 64'(wr_data[0]), 64'h8B120200);
      check("t1_addr", wr_addr[0], 64'd0);
      check("t1_latency", 64'(wr_cyc[0]), 64'(acc_cyc));
    end
    check("t1_done", 64'(done), 64'd1);
    check("t1_cpu_reset", 64'(cpu_reset), 64'd0);
    start = 1'b1;
    @(posedge clock);
    #1;
    check("t6_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t6_done", 64'(done), 64'd0);
    check("t6_words", 64'(words_loaded), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);
    start = 1'b0;

    // Reset mid-word: outputs return to reset values before the next clock edge.
    begin
      bit ok;
      prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h44;
      prog[4] = 8'h55; prog[5] = 8'h66;
      do_load(8, 0);
      check("t5_pre_addr", mem_addr, 64'd4);
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      send_byte(8'hA1, 1'b0, ok);
      send_byte(8'hA2, 1'b0, ok);
      #2 reset = 1'b1;
      #1;
      check("t5_in_ready", 64'(in_ready), 64'd0);
      check("t5_mem_addr", mem_addr, 64'd0);
      check("t5_mem_wdata", 64'(mem_wdata), 64'd0);
      check("t5_cpu_reset", 64'(cpu_reset), 64'd1);
      check("t5_words", 64'(words_loaded), 64'd0);
      check("t5_done_error", 64'({done, error}), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      prog[0] = 8'hC0; prog[1] = 8'hC1; prog[2] = 8'hC2; prog[3] = 8'hC3;
      do_load(4, 0);
      check("t5_reload_n", 64'(wr_data.size()), 64'd1);
      if (wr_addr.size() > 0) begin
        check("t5_reload_addr", wr_addr[0], 64'd0);
        check("t5_reload_data", 64'(wr_data[0]), 64'hC3C2C1C0);
      end
    end

    // Randomized programs with idle gaps between bytes.
    for (int r = 0; r < 40; r++) begin
      int n;
      int ne;
      n = int'($urandom_range(24, 1));
      for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
      do_load(n, 3);
      ne = exp_data.size();
      check($sformatf("rnd%0d_nwrites", r), 64'(wr_data.size()), 64'(ne));
      for (int k = 0; k < ne && k < wr_data.size(); k++) begin
        check($sformatf("rnd%0d_w%0d_data", r, k), 64'(wr_data[k]), 64'(exp_data[k]));
        check($sformatf("rnd%0d_w%0d_addr", r, k), wr_addr[k], 64'(4 * k));
      end
      check($sformatf("rnd%0d_done", r), 64'(done), 64'(m_ok));
      check($sformatf("rnd%0d_error", r), 64'(error), 64'(!m_ok));
      check($sformatf("rnd%0d_cpu_reset", r), 64'(cpu_reset), 64'(!m_ok));
      check($sformatf("rnd%0d_words", r), 64'(words_loaded), 64'(ne));
      check($sformatf("rnd%0d_ready_in_write", r), 64'(ready_in_write), 64'd0);
      check($sformatf("rnd%0d_in_ready", r), 64'(in_ready), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
